// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 8:1 mux.
// Rotating priority pointer plus a bounded hold time per grant.
module mux8_rr_arbiter #(
    parameter int HOLD_MAX = 4,
    parameter int CW       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       gnt_valid
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state;
    logic [2:0]    ptr;
    logic [CW-1:0] hold_cnt;

    logic [2:0]    scan_start;
    logic          win_found;
    logic [2:0]    win_idx;
    logic          hold_hit;
    logic          release_g;

    // First set bit scanning start, start+1, ... (mod 8).
    function automatic logic [3:0] pick(input logic [7:0] r,
                                        input logic [2:0] s);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            idx = s + 3'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        scan_start = (state == GRANT) ? sel + 3'd1 : ptr;
        {win_found, win_idx} = pick(req, scan_start);
        hold_hit  = (HOLD_MAX != 0) && (hold_cnt == CW'(HOLD_MAX));
        release_g = !req[sel] || hold_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            hold_cnt  <= '0;
            gnt       <= 8'h00;
            sel       <= 3'd0;
            gnt_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (win_found) begin
                        gnt       <= 8'b1 << win_idx;
                        sel       <= win_idx;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= CW'(1);
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!release_g) begin
                        if (hold_cnt != '1) hold_cnt <= hold_cnt + CW'(1);
                    end else begin
                        ptr <= sel + 3'd1;
                        // Owner is scanned last, so a lone requester is re-granted.
                        if (win_found) begin
                            gnt      <= 8'b1 << win_idx;
                            sel      <= win_idx;
                            hold_cnt <= CW'(1);
                        end else begin
                            gnt       <= 8'h00;
                            gnt_valid <= 1'b0;
                            hold_cnt  <= '0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
